// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch -- program counter and instruction fetch/issue sequencer.
//
// Fetches one word from instruction memory, presents it to decode as instr,
// waits for the datapath to release it (stall=0), then computes the next pc
// from the decode inputs sampled in that retire cycle.
//
// Handshake: imem_req is asserted in FETCH and held, with imem_addr stable,
// until a cycle in which imem_ready=1; that cycle transfers imem_rdata. An
// instruction retires in the first ISSUE cycle with stall=0.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   imem_req/imem_addr   fetch request and word-aligned address (= pc)
//   imem_ready/rdata     memory accept and returned instruction word
//   instr/instr_valid    registered instruction awaiting retirement
//   stall                datapath busy, blocks retirement
//   branch, zero         beq decode and ALU zero
//   bmnSignal, neg       bmn decode and memory-operand-negative flag
//   jalSignal            jal decode
//   jmaddSignal          jmadd decode
//   mem_target           memory-sourced target for bmn / jmadd
//   link_pc/link_we      pc+4 of retired instruction, one-cycle write pulse
//   misalign             one-cycle pulse when the target needed realigning
//   state_dbg            current FSM state (IDLE=0, FETCH=1, ISSUE=2)
// ---------------------------------------------------------------------------
module pc_fetch (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        bmnSignal,
    input  logic        neg,
    input  logic        jalSignal,
    input  logic        jmaddSignal,
    input  logic [31:0] mem_target,
    output logic [31:0] link_pc,
    output logic        link_we,
    output logic        misalign,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic [31:0] r_link_pc;
    logic        r_link_we;
    logic        r_misalign;

    logic        w_accept;
    logic        w_retire;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_jal_target;
    logic [31:0] w_target;

    // Target arithmetic; wraps modulo 2^32 naturally.
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_br_target  = w_pc_plus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_jal_target = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};

    // Next-pc priority: jmadd > jal > bmn-taken > beq-taken > sequential.
    always_comb begin
        w_target = w_pc_plus4;
        if (jmaddSignal) begin
            w_target = mem_target;
        end else if (jalSignal) begin
            w_target = w_jal_target;
        end else if (bmnSignal && neg) begin
            w_target = mem_target;
        end else if (branch && zero) begin
            w_target = w_br_target;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_retire    = 1'b0;
        imem_req    = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    w_retire    = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= 32'h0;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_link_pc     <= 32'h0;
            r_link_we     <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-armed by a retire.
            r_link_we  <= 1'b0;
            r_misalign <= 1'b0;
            if (w_accept) begin
                r_instr       <= imem_rdata;
                r_instr_valid <= 1'b1;
            end
            if (w_retire) begin
                r_pc          <= {w_target[31:2], 2'b00};
                r_instr_valid <= 1'b0;
                r_link_pc     <= w_pc_plus4;
                r_link_we     <= jalSignal | jmaddSignal;
                r_misalign    <= |w_target[1:0];
            end
        end
    end

    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign link_pc     = r_link_pc;
    assign link_we     = r_link_we;
    assign misalign    = r_misalign;
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch -- self-checking bench for pc_fetch.
// A per-instruction model (pc, current instruction, link value, pulses) is
// updated by the driver tasks at each fetch accept / retire; one process
// compares every DUT output against it on each falling edge.
// ---------------------------------------------------------------------------
module tb_pc_fetch;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall = 1'b0;
  logic        branch = 1'b0, zero = 1'b0, bmnSignal = 1'b0, neg = 1'b0;
  logic        jalSignal = 1'b0, jmaddSignal = 1'b0;
  logic [31:0] mem_target = 32'h0;
  logic [31:0] link_pc;
  logic        link_we;
  logic        misalign;
  logic [1:0]  state_dbg;

  pc_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .branch      (branch),
    .zero        (zero),
    .bmnSignal   (bmnSignal),
    .neg         (neg),
    .jalSignal   (jalSignal),
    .jmaddSignal (jmaddSignal),
    .mem_target  (mem_target),
    .link_pc     (link_pc),
    .link_we     (link_we),
    .misalign    (misalign),
    .state_dbg   (state_dbg)
  );

  // ---------------- model state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          m_chk    = 1'b0;
  logic        m_req    = 1'b0;
  logic [31:0] m_pc     = 32'h0;
  logic        m_valid  = 1'b0;
  logic [31:0] m_instr  = 32'h0;
  logic [31:0] m_link   = 32'h0;
  logic        m_lwe    = 1'b0;
  logic        m_mis    = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          obs_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next pc per the decode rules, straight from the instruction set view.
  task automatic model_retire(input logic [31:0] pc, input logic [31:0] iw,
                              input logic jm, input logic jal, input logic bmn, input logic ng,
                              input logic br, input logic z, input logic [31:0] mt,
                              output logic [31:0] npc, output logic mis, output logic lwe);
    logic [31:0] p4;
    logic [31:0] t;
    logic [31:0] off;
    p4  = pc + 32'd4;
    off = {{16{iw[15]}}, iw[15:0]} * 32'd4;
    if (jm)             t = mt;
    else if (jal)       t = {p4[31:28], iw[25:0], 2'b00};
    else if (bmn && ng) t = mt;
    else if (br && z)   t = p4 + off;
    else                t = p4;
    mis = (t[1:0] != 2'b00);
    npc = t & 32'hFFFF_FFFC;
    lwe = jal | jm;
  endtask

  always @(posedge clk) cyc++;

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_chk) begin
      check("imem_req", imem_req, m_req);
      if (m_req) check("imem_addr", imem_addr, m_pc);
      check("instr_valid", instr_valid, m_valid);
      if (m_valid || !rst_n) check("instr", instr, m_instr);
      check("link_pc", link_pc, m_link);
      check("link_we", link_we, m_lwe);
      check("misalign", misalign, m_mis);
      if (imem_req && imem_ready && rst_n) begin
        obs_q.push_back(imem_addr);
        obs_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_garbage();
    branch      = 1'($urandom_range(0, 1));
    zero        = 1'($urandom_range(0, 1));
    bmnSignal   = 1'($urandom_range(0, 1));
    neg         = 1'($urandom_range(0, 1));
    jalSignal   = 1'($urandom_range(0, 1));
    jmaddSignal = 1'($urandom_range(0, 1));
    mem_target  = $urandom;
  endtask

  task automatic model_reset();
    m_req = 1'b0; m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0;
    m_link = 32'h0; m_lwe = 1'b0; m_mis = 1'b0;
  endtask

  // Holds reset over two edges, releases, and models the single IDLE cycle.
  task automatic finish_reset();
    repeat (2) @(posedge clk);
    #1;
    imem_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_req = 1'b1;
  endtask

  task automatic clear_pulses();
    m_lwe = 1'b0;
    m_mis = 1'b0;
  endtask

  // One instruction: fw cycles of memory wait, then sc stall cycles, then retire.
  task automatic do_instr(input logic [31:0] word, input int fw, input int sc,
                          input logic jm, input logic jal, input logic bmn, input logic ng,
                          input logic br, input logic z, input logic [31:0] mt);
    logic [31:0] npc;
    logic        mis;
    logic        lwe;
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    stall      = 1'($urandom_range(0, 1));
    drive_garbage();
    for (int i = 0; i < fw; i++) begin
      @(posedge clk);
      #1;
      clear_pulses();
      imem_rdata = $urandom;
      drive_garbage();
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    @(posedge clk);
    #1;
    clear_pulses();
    m_req = 1'b0; m_valid = 1'b1; m_instr = word;
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    for (int i = 0; i < sc; i++) begin
      stall = 1'b1;
      drive_garbage();
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    jmaddSignal = jm; jalSignal = jal; bmnSignal = bmn; neg = ng;
    branch = br; zero = z; mem_target = mt;
    @(posedge clk);
    #1;
    model_retire(m_pc, word, jm, jal, bmn, ng, br, z, mt, npc, mis, lwe);
    m_link  = m_pc + 32'd4;
    m_pc    = npc;
    m_mis   = mis;
    m_lwe   = lwe;
    m_valid = 1'b0;
    m_req   = 1'b1;
  endtask

  task automatic idle(input int n);
    imem_ready = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      clear_pulses();
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #3;
    rst_n = 1'b0;
    model_reset();
    m_chk = 1'b1;
    @(negedge clk);
    #1;
    check("rst_req", imem_req, 32'h0);
    check("rst_valid", instr_valid, 32'h0);
    check("rst_state", state_dbg, 32'h0);
    finish_reset();
    check("first_req", imem_req, 32'h1);
    check("first_addr", imem_addr, 32'h0);

    // Sequential fetch: 0,4,8,12, one instruction every two cycles.
    obs_q.delete();
    obs_cyc_q.delete();
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 4; i++)
      do_instr($urandom, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    check("seq_count", obs_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      check("seq_addr", obs_q[i], exp_q[i]);
      if (i > 0) check("seq_period", obs_cyc_q[i] - obs_cyc_q[i-1], 32'd2);
    end
    check("seq_next", imem_addr, 32'h10);

    // beq at 0x40, offset -2 words.
    do_instr($urandom, 0, 0, 1, 0, 0, 0, 0, 0, 32'h40);
    check("jm_to_40", imem_addr, 32'h40);
    check("jm_link", link_pc, 32'h14);
    do_instr(32'h1000_FFFE, 1, 1, 0, 0, 0, 0, 1, 1, 32'h0);
    check("beq_taken", imem_addr, 32'h3C);
    do_instr($urandom, 0, 0, 1, 0, 0, 0, 0, 0, 32'h40);
    do_instr(32'h1000_FFFE, 0, 2, 0, 0, 0, 0, 1, 0, 32'h0);
    check("beq_not_taken", imem_addr, 32'h44);

    // jal at 0x100 back to itself.
    do_instr($urandom, 0, 0, 1, 0, 0, 0, 0, 0, 32'h100);
    do_instr(32'h0C00_0040, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    check("jal_pc", imem_addr, 32'h100);
    check("jal_link", link_pc, 32'h104);
    check("jal_we", link_we, 32'h1);

    // jmadd over bmn, misaligned memory target.
    do_instr($urandom, 0, 0, 1, 0, 1, 1, 0, 0, 32'h203);
    check("jmadd_pc", imem_addr, 32'h200);
    check("jmadd_mis", misalign, 32'h1);
    check("jmadd_we", link_we, 32'h1);

    // Memory wait 3 cycles, stall 5 cycles.
    do_instr(32'hA5A5_5A5A, 3, 5, 0, 0, 0, 0, 0, 0, 32'h0);
    check("stall_pc", imem_addr, 32'h204);
    check("stall_link", link_pc, 32'h204);

    // bmn taken, then bmn not taken falling to beq, then jal over beq.
    do_instr($urandom, 0, 0, 0, 0, 1, 1, 0, 0, 32'h300);
    check("bmn_pc", imem_addr, 32'h300);
    check("bmn_no_we", link_we, 32'h0);
    do_instr(32'h0000_0004, 0, 1, 0, 0, 1, 0, 1, 1, 32'h888);
    check("bmn_nt_beq", imem_addr, 32'h314);
    do_instr(32'h0C00_0100, 0, 0, 0, 1, 0, 0, 1, 1, 32'h0);
    check("jal_over_beq", imem_addr, 32'h400);

    // pc+4 wrap.
    do_instr($urandom, 0, 0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    do_instr($urandom, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    check("wrap_pc", imem_addr, 32'h0);
    check("wrap_link", link_pc, 32'h0);
    check("wrap_mis", misalign, 32'h0);

    // Move off zero, then reset mid-FETCH while memory is ready.
    do_instr($urandom, 0, 0, 1, 0, 0, 0, 0, 0, 32'h80);
    idle(1);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("midrst_valid", instr_valid, 32'h0);
    check("midrst_instr", instr, 32'h0);
    finish_reset();
    check("midrst_addr", imem_addr, 32'h0);
    check("midrst_req", imem_req, 32'h1);
    do_instr(32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    check("post_rst_pc", imem_addr, 32'h4);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
